// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring shift-subtract divide, one bit per cycle, with single-cycle special cases.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              neg_q, neg_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    // Operand decode for the op presented in IDLE.
    logic            in_is_div, in_is_rem, in_s1, in_s2;
    logic [XLEN-1:0] in_mag1, in_mag2;
    logic            div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] special_res;

    always_comb begin
        in_is_div   = funct3[2];
        in_is_rem   = funct3[2] & funct3[1];
        in_s1       = op1[XLEN-1] & (funct3 inside {F_MULH, F_MULHSU, F_DIV, F_REM});
        in_s2       = op2[XLEN-1] & (funct3 inside {F_MULH, F_DIV, F_REM});
        in_mag1     = in_s1 ? -op1 : op1;
        in_mag2     = in_s2 ? -op2 : op2;
        div_zero    = in_is_div && (op2 == '0);
        div_ovf     = (funct3 inside {F_DIV, F_REM})
                      && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = in_is_rem ? op1 : '1;
        else if (div_ovf)
            special_res = in_is_rem ? '0 : op1;
        accept      = (state_q == IDLE) && valid_in && !flush;
    end

    // One iteration of each datapath; acc holds {hi, lo} of product or {remainder, quotient}.
    logic [XLEN:0]     mul_sum, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] mul_next, div_next, iter;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_sel, final_res;

    always_comb begin
        mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next    = {mul_sum, acc_q[XLEN-1:1]};
        div_diff    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_ok      = !div_diff[XLEN];
        div_next    = {div_ok ? div_diff[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1],
                       acc_q[XLEN-2:0], div_ok};
        iter        = funct3_q[2] ? div_next : mul_next;

        prod_signed = neg_q ? -iter : iter;
        div_sel     = funct3_q[1] ? iter[2*XLEN-1:XLEN] : iter[XLEN-1:0];
        if (funct3_q[2])
            final_res = neg_q ? -div_sel : div_sel;
        else if (funct3_q[1:0] == 2'b00)
            final_res = iter[XLEN-1:0];
        else
            final_res = prod_signed[2*XLEN-1:XLEN];
    end

    // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = funct3;
                    rd_d     = rd_in;
                    neg_d    = in_is_rem ? in_s1 : (in_s1 ^ in_s2);
                    opnd_d   = in_is_div ? in_mag2 : in_mag1;
                    acc_d    = {{XLEN{1'b0}}, (in_is_div ? in_mag1 : in_mag2)};
                    count_d  = '0;
                    if (special) begin
                        result_d = special_res;
                        rd_out_d = rd_in;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                // A flush on the final iteration still wins: nothing is written back.
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = iter;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(XLEN-1)) begin
                        result_d = final_res;
                        rd_out_d = rd_q;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign stall        = (accept && !special) || (state_q == CALC);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE) && !flush;
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors with hand-computed results,
// latency/stall checks per op, plus flush and asynchronous reset scenarios.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        stall, busy, result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    mul_div_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .funct3       (funct3),
        .op1          (op1),
        .op2          (op2),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: result=0x%08h rd_out=%0d with nothing expected",
                         result, rd_out);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input bit special);
        int stall_cnt;
        int seen;
        stall_cnt = 0;
        seen      = -1;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        funct3   = f;
        op1      = a;
        op2      = b;
        rd_in    = rd;
        exp_q.push_back(exp_t'{res: exp_res, rd: rd});
        @(negedge clk);
        if (stall) stall_cnt++;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (result_valid) begin
                seen = i;
                break;
            end
        end
        check({name, " latency"}, 32'(seen), special ? 32'd0 : 32'd32);
        check({name, " stall_cycles"}, 32'(stall_cnt), special ? 32'd0 : 32'd33);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset result_valid", {31'b0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'b0, rd_out}, 32'd0);
        rst_n = 1'b1;

        run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        5'd5,  32'd42,        1'b0);
        run_op("mulh_m1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000,  1'b0);
        run_op("mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF,  1'b0);
        run_op("mulhu_m1",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE,  1'b0);
        run_op("mul_m1",       3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001,  1'b0);
        run_op("mulh_min_x2",  3'b001, 32'h80000000, 32'd2,        5'd16, 32'hFFFFFFFF,  1'b0);
        run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD,  1'b0);
        run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF,  1'b0);
        run_op("divu_20_6",    3'b101, 32'd20,       32'd6,        5'd8,  32'd3,         1'b0);
        run_op("remu_20_6",    3'b111, 32'd20,       32'd6,        5'd10, 32'd2,         1'b0);
        run_op("divu_by0",     3'b101, 32'h1234,     32'd0,        5'd11, 32'hFFFFFFFF,  1'b1);
        run_op("rem_by0",      3'b110, 32'h1234,     32'd0,        5'd12, 32'h1234,      1'b1);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000,  1'b1);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,         1'b1);
        run_op("divu_big",     3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,         1'b0);

        // Flush mid-CALC at count 10: the DIV must vanish without writeback.
        @(posedge clk);
        #1;
        valid_in = 1'b1; funct3 = 3'b100; op1 = 32'd100; op2 = 32'd3; rd_in = 5'd9;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush stall", {31'b0, stall}, 32'd0);
        check("flush result_valid", {31'b0, result_valid}, 32'd0);
        repeat (3) @(negedge clk);

        // Flush in IDLE blocks acceptance.
        @(posedge clk);
        #1;
        valid_in = 1'b1; flush = 1'b1; funct3 = 3'b000; op1 = 32'd2; op2 = 32'd2; rd_in = 5'd17;
        @(negedge clk);
        check("idle_flush stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush busy", {31'b0, busy}, 32'd0);

        run_op("mul_3x4",      3'b000, 32'd3,        32'd4,        5'd20, 32'd12,        1'b0);

        // Asynchronous reset in the middle of CALC.
        @(posedge clk);
        #1;
        valid_in = 1'b1; funct3 = 3'b000; op1 = 32'd5; op2 = 32'd5; rd_in = 5'd3;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset stall", {31'b0, stall}, 32'd0);
        check("midreset result_valid", {31'b0, result_valid}, 32'd0);
        check("midreset result", result, 32'd0);
        check("midreset rd_out", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mulhu_2p16",   3'b011, 32'h00010000, 32'h00010000, 5'd21, 32'd1,         1'b0);
        run_op("div_100_m3",   3'b100, 32'd100,      32'hFFFFFFFD, 5'd22, 32'hFFFFFFDF,  1'b0);
        run_op("rem_100_m3",   3'b110, 32'd100,      32'hFFFFFFFD, 5'd23, 32'd1,         1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
